// File: rtl/fizzbuzz_tx_sequencer.sv
// fizzbuzz_tx_sequencer: streams the FizzBuzz text for n = 1..MAX_N byte by
// byte into the UART transmitter, handling the start/busy handshake.
// Numbers are kept in BCD alongside mod-3/mod-5 counters, so no dividers.
// Build option: define FIZZBUZZ_CRLF_EN for CR+LF line endings (default LF).
module fizzbuzz_tx_sequencer #(
  parameter int unsigned MAX_N  = 100,
  parameter int unsigned DIGITS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       busy,
  output logic       done
);

  localparam int unsigned BCD_W = 4 * DIGITS;
`ifdef FIZZBUZZ_CRLF_EN
  localparam int unsigned TERM_LEN = 2;
`else
  localparam int unsigned TERM_LEN = 1;
`endif
  localparam int unsigned TEXT_MAX = (DIGITS > 8) ? DIGITS : 8;
  localparam int unsigned LINE_MAX = TEXT_MAX + TERM_LEN;
  localparam int unsigned IDX_W    = $clog2(LINE_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EMIT,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_ADVANCE,
    S_FINISH
  } state_t;

  typedef enum logic [1:0] {
    CLS_NUM,
    CLS_FIZZ,
    CLS_BUZZ,
    CLS_FIZZBUZZ
  } line_cls_t;

  // Binary to BCD at elaboration time, used only for the MAX_N compare
  function automatic logic [BCD_W-1:0] to_bcd(input int unsigned v);
    logic [BCD_W-1:0] r;
    int unsigned      x;
    r = '0;
    x = v;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  localparam logic [BCD_W-1:0] MAX_BCD = to_bcd(MAX_N);

  // Line class from the residues; a zero residue means divisible
  function automatic line_cls_t line_cls(input logic [1:0] m3v, input logic [2:0] m5v);
    line_cls_t c;
    if (m3v == 2'd0 && m5v == 3'd0) c = CLS_FIZZBUZZ;
    else if (m3v == 2'd0)           c = CLS_FIZZ;
    else if (m5v == 3'd0)           c = CLS_BUZZ;
    else                            c = CLS_NUM;
    return c;
  endfunction

  // Significant decimal digits, never fewer than one
  function automatic int unsigned num_digits(input logic [BCD_W-1:0] n);
    int unsigned nd;
    nd = 1;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (n[4*d +: 4] != 4'd0) nd = d + 1;
    end
    return nd;
  endfunction

  // Printable length of a line, excluding the terminator
  function automatic int unsigned text_len(input line_cls_t c, input logic [BCD_W-1:0] n);
    int unsigned len;
    case (c)
      CLS_FIZZBUZZ:       len = 8;
      CLS_FIZZ, CLS_BUZZ: len = 4;
      default:            len = num_digits(n);
    endcase
    return len;
  endfunction

  // Characters of "FizzBuzz"; "Buzz" reuses the upper half
  function automatic logic [7:0] word_char(input logic [2:0] i);
    logic [7:0] ch;
    case (i)
      3'd0:    ch = 8'h46;  // F
      3'd1:    ch = 8'h69;  // i
      3'd4:    ch = 8'h42;  // B
      3'd5:    ch = 8'h75;  // u
      default: ch = 8'h7A;  // z
    endcase
    return ch;
  endfunction

  // One BCD digit selected by position (0 = least significant)
  function automatic logic [3:0] bcd_digit(input logic [BCD_W-1:0] n, input int unsigned pos);
    logic [3:0] dig;
    dig = 4'd0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (d == pos) dig = n[4*d +: 4];
    end
    return dig;
  endfunction

  // Byte at position idx_v of the line described by (n, m3, m5)
  function automatic logic [7:0] char_at(input logic [BCD_W-1:0] n,
                                         input logic [1:0]       m3v,
                                         input logic [2:0]       m5v,
                                         input logic [IDX_W-1:0] idx_v);
    line_cls_t   c;
    int unsigned tl;
    int unsigned i;
    logic [7:0]  ch;
    c  = line_cls(m3v, m5v);
    tl = text_len(c, n);
    i  = 32'(idx_v);
    ch = 8'h0A;
    if (i < tl) begin
      case (c)
        CLS_FIZZBUZZ, CLS_FIZZ: ch = word_char(3'(i));
        CLS_BUZZ:               ch = word_char(3'(i + 4));
        default:                ch = {4'h3, bcd_digit(n, tl - 1 - i)};
      endcase
    end
`ifdef FIZZBUZZ_CRLF_EN
    else if (i == tl) begin
      ch = 8'h0D;
    end
`endif
    return ch;
  endfunction

  // Index of the final terminator byte of the current line
  function automatic logic [IDX_W-1:0] last_idx(input logic [BCD_W-1:0] n,
                                                 input logic [1:0]       m3v,
                                                 input logic [2:0]       m5v);
    return IDX_W'(text_len(line_cls(m3v, m5v), n) + TERM_LEN - 1);
  endfunction

  // Decimal increment with per-digit carry at 9 -> 0
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] n);
    logic [BCD_W-1:0] r;
    logic             carry;
    r     = n;
    carry = 1'b1;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (r[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = r[4*d +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  state_t           state, nxt_state;
  logic [BCD_W-1:0] n_bcd, nxt_n_bcd;
  logic [1:0]       m3, nxt_m3;
  logic [2:0]       m5, nxt_m5;
  logic [IDX_W-1:0] idx, nxt_idx;
  logic [7:0]       nxt_tx_data;
  logic             nxt_tx_start;
  logic             nxt_busy;
  logic             nxt_done;

  // Next-state and next-output logic; outputs are derived from the next state
  always_comb begin
    nxt_state    = state;
    nxt_n_bcd    = n_bcd;
    nxt_m3       = m3;
    nxt_m5       = m5;
    nxt_idx      = idx;
    nxt_tx_data  = tx_data;
    nxt_tx_start = 1'b0;
    nxt_busy     = 1'b0;
    nxt_done     = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) nxt_state = S_LOAD;
      end
      S_LOAD: begin
        nxt_n_bcd = BCD_W'(1);
        nxt_m3    = 2'd1;
        nxt_m5    = 3'd1;
        nxt_idx   = '0;
        nxt_state = S_EMIT;
      end
      S_EMIT: begin
        nxt_state = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (tx_busy) nxt_state = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (idx != last_idx(n_bcd, m3, m5)) begin
            nxt_idx   = idx + IDX_W'(1);
            nxt_state = S_EMIT;
          end else begin
            nxt_state = S_ADVANCE;
          end
        end
      end
      S_ADVANCE: begin
        if (n_bcd == MAX_BCD) begin
          nxt_state = S_FINISH;
        end else begin
          nxt_n_bcd = bcd_inc(n_bcd);
          nxt_m3    = (m3 == 2'd2) ? 2'd0 : m3 + 2'd1;
          nxt_m5    = (m5 == 3'd4) ? 3'd0 : m5 + 3'd1;
          nxt_idx   = '0;
          nxt_state = S_EMIT;
        end
      end
      S_FINISH: begin
        nxt_state = S_IDLE;
      end
      default: begin
        nxt_state = S_IDLE;
      end
    endcase

    // Byte is loaded on entry to EMIT and then held until the next EMIT
    if (nxt_state == S_EMIT) begin
      nxt_tx_start = 1'b1;
      nxt_tx_data  = char_at(nxt_n_bcd, nxt_m3, nxt_m5, nxt_idx);
    end
    nxt_busy = (nxt_state != S_IDLE);
    nxt_done = (nxt_state == S_FINISH);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      n_bcd    <= '0;
      m3       <= 2'd0;
      m5       <= 3'd0;
      idx      <= '0;
      tx_data  <= 8'h00;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= nxt_state;
      n_bcd    <= nxt_n_bcd;
      m3       <= nxt_m3;
      m5       <= nxt_m5;
      idx      <= nxt_idx;
      tx_data  <= nxt_tx_data;
      tx_start <= nxt_tx_start;
      busy     <= nxt_busy;
      done     <= nxt_done;
    end
  end

endmodule

// File: tb/tb_fizzbuzz_tx_sequencer.sv
// Bench for fizzbuzz_tx_sequencer: a UART transmitter model captures each
// byte and compares it against a reference stream queued at run start.
// Expected terminators follow FIZZBUZZ_CRLF_EN exactly as the DUT does.
module tb_fizzbuzz_tx_sequencer;

  localparam int unsigned MAX_N  = 110;
  localparam int unsigned DIGITS = 3;
`ifdef FIZZBUZZ_CRLF_EN
  localparam int TERM_LEN = 2;
  localparam int CR_EXP   = 110;
`else
  localparam int TERM_LEN = 1;
  localparam int CR_EXP   = 0;
`endif

  logic       clk     = 1'b0;
  logic       rst     = 1'b0;
  logic       start   = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];

  int ack_dly    = 1;
  int busy_len   = 10;
  bit stall_hold = 1'b0;
  bit pending    = 1'b0;
  int ack_cnt    = 0;
  int busy_cnt   = 0;
  int done_cnt   = 0;
  int lf_cnt     = 0;

  fizzbuzz_tx_sequencer #(
    .MAX_N  (MAX_N),
    .DIGITS (DIGITS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Reference stream built with plain integer arithmetic
  function automatic void push_stream(input int max_n);
    string s;
    for (int n = 1; n <= max_n; n++) begin
      if (n % 15 == 0)     s = "FizzBuzz";
      else if (n % 3 == 0) s = "Fizz";
      else if (n % 5 == 0) s = "Buzz";
      else                 s = $sformatf("%0d", n);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s.getc(i));
`ifdef FIZZBUZZ_CRLF_EN
      exp_q.push_back(8'h0D);
`endif
      exp_q.push_back(8'h0A);
    end
  endfunction

  // Transmitter model and scoreboard
  always @(negedge clk) begin
    logic [7:0] exp_b;
    bit         seen;
    if (!rst) begin
      tx_busy  = 1'b0;
      pending  = 1'b0;
      ack_cnt  = 0;
      busy_cnt = 0;
    end else begin
      seen = (tx_start === 1'b1);
      if (seen) begin
        checks++;
        if (pending || tx_busy) begin
          errors++;
          $display("FAIL handshake: tx_start with transmitter busy (data %02h), required idle transmitter", tx_data);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra: got byte %02h, required no further byte", tx_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (tx_data !== exp_b) begin
            errors++;
            $display("FAIL stream_byte[%0d]: got %02h, required %02h", cap_q.size(), tx_data, exp_b);
          end
        end
        cap_q.push_back(tx_data);
        if (tx_data == 8'h0A) lf_cnt++;
      end
      if (pending) begin
        ack_cnt--;
        if (ack_cnt <= 0) begin
          pending  = 1'b0;
          tx_busy  = 1'b1;
          busy_cnt = busy_len;
        end
      end else if (tx_busy && !stall_hold) begin
        busy_cnt--;
        if (busy_cnt <= 0) tx_busy = 1'b0;
      end
      if (seen) begin
        pending = 1'b1;
        ack_cnt = ack_dly;
      end
    end
  end

  // done must come with busy high, after every expected byte went out
  always @(negedge clk) begin
    if (rst && done === 1'b1) begin
      done_cnt++;
      checks++;
      if (busy !== 1'b1 || exp_q.size() != 0 || tx_busy !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse: busy=%0b bytes_left=%0d tx_busy=%0b, required busy=1 bytes_left=0 tx_busy=0",
                 busy, exp_q.size(), tx_busy);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %02h, required 00", tx_data); end
    checks++;
    if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %0b, required 0", tx_start); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b, required 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b, required 0", done); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx_start !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start: busy=%0b tx_start=%0b, required 0 0", busy, tx_start);
    end
  endtask

  task automatic test_stream();
    bit ok;
    int d0;
    exp_q.delete();
    cap_q.delete();
    lf_cnt   = 0;
    busy_len = 10;
    push_stream(MAX_N);
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL start_to_busy: got %0b, required 1", busy); end
    checks++;
    if (tx_start !== 1'b0) begin errors++; $display("FAIL tx_start_early: got %0b, required 0", tx_start); end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h31) begin
      errors++;
      $display("FAIL first_tx_start: tx_start=%0b tx_data=%02h, required 1 31", tx_start, tx_data);
    end
    run_until_done(30000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stream_timeout: done seen=%0b, required 1", ok); end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL stream_done_count: got %0d, required 1", done_cnt - d0); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL stream_short: %0d bytes missing, required 0", exp_q.size()); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_done: got %0b, required 0", busy); end
  endtask

  // Line-level view of the stream captured by test_stream
  task automatic test_digit_carry();
    string lines[$];
    string cur;
    int    cr;
    int    lead0;
    cur = "";
    cr  = 0;
    foreach (cap_q[i]) begin
      if (cap_q[i] == 8'h0A) begin
        lines.push_back(cur);
        cur = "";
      end else if (cap_q[i] == 8'h0D) begin
        cr++;
      end else begin
        cur = $sformatf("%s%c", cur, cap_q[i]);
      end
    end
    checks++;
    if (lines.size() != 110) begin errors++; $display("FAIL line_count: got %0d, required 110", lines.size()); end
    if (lines.size() == 110) begin
      checks++;
      if (lines[0] != "1") begin errors++; $display("FAIL line_1: got '%s', required '1'", lines[0]); end
      checks++;
      if (lines[9] != "Buzz") begin errors++; $display("FAIL line_10: got '%s', required 'Buzz'", lines[9]); end
      checks++;
      if (lines[14] != "FizzBuzz") begin errors++; $display("FAIL line_15: got '%s', required 'FizzBuzz'", lines[14]); end
      checks++;
      if (lines[98] != "Fizz") begin errors++; $display("FAIL line_99: got '%s', required 'Fizz'", lines[98]); end
      checks++;
      if (lines[99] != "Buzz") begin errors++; $display("FAIL line_100: got '%s', required 'Buzz'", lines[99]); end
      checks++;
      if (lines[100] != "101") begin errors++; $display("FAIL line_101: got '%s', required '101'", lines[100]); end
      checks++;
      if (lines[104] != "FizzBuzz") begin errors++; $display("FAIL line_105: got '%s', required 'FizzBuzz'", lines[104]); end
      checks++;
      if (lines[109] != "Buzz") begin errors++; $display("FAIL line_110: got '%s', required 'Buzz'", lines[109]); end
    end
    lead0 = 0;
    foreach (lines[i]) begin
      if (lines[i].len() > 0 && lines[i].getc(0) == 8'h30) lead0++;
    end
    checks++;
    if (lead0 != 0) begin errors++; $display("FAIL leading_zero: %0d lines, required 0", lead0); end
    checks++;
    if (cr != CR_EXP) begin errors++; $display("FAIL cr_count: got %0d, required %0d", cr, CR_EXP); end
  endtask

  task automatic test_ignored_start();
    bit ok;
    bit reached;
    int d0;
    int n_after;
    exp_q.delete();
    cap_q.delete();
    lf_cnt   = 0;
    busy_len = 2;
    push_stream(MAX_N);
    d0 = done_cnt;
    pulse_start();
    reached = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      #1;
      if (lf_cnt >= 6) begin reached = 1'b1; break; end
    end
    checks++;
    if (!reached) begin errors++; $display("FAIL ignored_reach_line7: lines=%0d, required 6", lf_cnt); end
    repeat (4) @(negedge clk);
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL ignored_busy: got %0b, required 1", busy); end
    run_until_done(20000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ignored_timeout: done seen=%0b, required 1", ok); end
    n_after = cap_q.size();
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL ignored_done_count: got %0d, required 1", done_cnt - d0); end
    checks++;
    if (busy !== 1'b0 || cap_q.size() != n_after) begin
      errors++;
      $display("FAIL ignored_no_restart: busy=%0b new_bytes=%0d, required 0 0", busy, cap_q.size() - n_after);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL ignored_stream_short: %0d bytes missing, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_midline();
    bit ok;
    bit reached;
    int target;
    int viol;
    int d0;
    exp_q.delete();
    cap_q.delete();
    busy_len = 2;
    push_stream(MAX_N);
    pulse_start();
    target  = 5 + 2 * TERM_LEN;
    reached = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      #1;
      if (cap_q.size() >= target) begin reached = 1'b1; break; end
    end
    checks++;
    if (!reached || cap_q[target-1] !== 8'h7A || tx_start !== 1'b1) begin
      errors++;
      $display("FAIL midline_reach_z: bytes=%0d tx_start=%0b, required %0d bytes ending 7a with tx_start=1",
               cap_q.size(), tx_start, target);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (tx_start !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL midline_reset_outputs: tx_start=%0b busy=%0b done=%0b tx_data=%02h, required 0 0 0 00",
               tx_start, busy, done, tx_data);
    end
    viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (tx_start !== 1'b0 || busy !== 1'b0) viol++;
    end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL midline_quiet: %0d active cycles in reset, required 0", viol); end
    exp_q.delete();
    cap_q.delete();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    push_stream(MAX_N);
    d0 = done_cnt;
    pulse_start();
    run_until_done(20000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midline_restart_timeout: done seen=%0b, required 1", ok); end
    checks++;
    if (cap_q.size() == 0 || cap_q[0] !== 8'h31) begin
      errors++;
      $display("FAIL midline_restart_first: bytes=%0d, required first byte 31", cap_q.size());
    end
    checks++;
    if (done_cnt - d0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL midline_restart_stream: done=%0d bytes_left=%0d, required 1 0", done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_stalled_tx();
    bit         ok;
    bit         reached;
    int         viol;
    int         n0;
    int         d0;
    logic [7:0] held;
    exp_q.delete();
    cap_q.delete();
    busy_len = 2;
    push_stream(MAX_N);
    d0 = done_cnt;
    pulse_start();
    reached = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      #1;
      if (cap_q.size() >= 4 && tx_busy === 1'b1) begin reached = 1'b1; break; end
    end
    checks++;
    if (!reached) begin errors++; $display("FAIL stall_reach: bytes=%0d, required busy transmitter after 4 bytes", cap_q.size()); end
    stall_hold = 1'b1;
    held       = tx_data;
    n0         = cap_q.size();
    viol       = 0;
    repeat (1000) begin
      @(negedge clk);
      #1;
      if (tx_start !== 1'b0 || tx_data !== held || busy !== 1'b1) viol++;
    end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL stall_stable: %0d bad cycles, required 0", viol); end
    checks++;
    if (cap_q.size() != n0) begin errors++; $display("FAIL stall_no_bytes: got %0d new bytes, required 0", cap_q.size() - n0); end
    stall_hold = 1'b0;
    run_until_done(20000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_timeout: done seen=%0b, required 1", ok); end
    checks++;
    if (done_cnt - d0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_resume: done=%0d bytes_left=%0d, required 1 0", done_cnt - d0, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_digit_carry();
    test_ignored_start();
    test_reset_midline();
    test_stalled_tx();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
